// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry: default resolution and the pixel-count / address-width
// derivation used by the frame buffer, the VGA scanout and the frame sequencer.
package fb_pkg;

  localparam int FB_HOR_DEFAULT = 640;
  localparam int FB_VER_DEFAULT = 480;

  function automatic int fb_total_pixels(input int hor, input int ver);
    return hor * ver;
  endfunction

  // A single-pixel buffer still needs a one-bit address.
  function automatic int fb_addr_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  localparam int FB_DEFAULT_ADDR_WIDTH =
    fb_addr_width(fb_total_pixels(FB_HOR_DEFAULT, FB_VER_DEFAULT));

endpackage

// File: rtl/frame_sequencer_if.sv
// Handshake and write-port bundle between the frame sequencer (slave) and the
// plotter / VGA timing / frame buffer environment (master).
interface frame_sequencer_if #(
  parameter int ADDR_WIDTH = fb_pkg::FB_DEFAULT_ADDR_WIDTH
);

  logic                  frame_req;
  logic                  vblank;
  logic                  draw_start;
  logic                  draw_done;
  logic                  plot_we;
  logic [ADDR_WIDTH-1:0] plot_addr;
  logic                  plot_data;
  logic                  fb_write_enable;
  logic [ADDR_WIDTH-1:0] fb_write_addr;
  logic                  fb_write_data;
  logic                  fb_swap;
  logic                  busy;
  logic                  frame_done;

  modport slave (
    input  frame_req, vblank, draw_done, plot_we, plot_addr, plot_data,
    output draw_start, fb_write_enable, fb_write_addr, fb_write_data,
           fb_swap, busy, frame_done
  );

  modport master (
    output frame_req, vblank, draw_done, plot_we, plot_addr, plot_data,
    input  draw_start, fb_write_enable, fb_write_addr, fb_write_data,
           fb_swap, busy, frame_done
  );

endinterface

// File: rtl/frame_sequencer.sv
// Per-frame controller for the double-buffered 1-bpp frame buffer:
// clear -> plotter draw -> wait for vblank rising edge -> single-cycle swap.
module frame_sequencer
  import fb_pkg::*;
#(
  parameter int   HOR_ACTIVE_PIXELS = FB_HOR_DEFAULT,
  parameter int   VER_ACTIVE_PIXELS = FB_VER_DEFAULT,
  parameter logic CLEAR_VALUE       = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_sequencer_if.slave  bus
);

  localparam int TOTAL_PIXELS = fb_total_pixels(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
  localparam int ADDR_WIDTH   = fb_addr_width(TOTAL_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TOTAL_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   PIXEL_SPAN = (ADDR_WIDTH + 1)'(TOTAL_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CLEAR       = 3'd1,
    S_DRAW        = 3'd2,
    S_WAIT_VBLANK = 3'd3,
    S_SWAP        = 3'd4
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  start_armed_r;
  logic                  vblank_q_r;
  logic [1:0]            rst_sync_r;
  logic                  rst_int_n_s;
  logic                  plot_in_range_s;
  logic                  fb_we_r;
  logic [ADDR_WIDTH-1:0] fb_addr_r;
  logic                  fb_data_r;
  logic                  fb_swap_r;
  logic                  frame_done_r;
  logic                  draw_start_r;
  logic                  busy_r;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Out-of-range plotter addresses are dropped rather than wrapped.
  always_comb begin
    plot_in_range_s = 1'b0;
    if ({1'b0, bus.plot_addr} < PIXEL_SPAN) begin
      plot_in_range_s = 1'b1;
    end else begin
      plot_in_range_s = 1'b0;
    end
  end

  // Frame sequencing FSM with registered write-port and handshake outputs.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r       <= S_IDLE;
      cnt_r         <= '0;
      start_armed_r <= 1'b0;
      vblank_q_r    <= 1'b0;
      fb_we_r       <= 1'b0;
      fb_addr_r     <= '0;
      fb_data_r     <= 1'b0;
      fb_swap_r     <= 1'b0;
      frame_done_r  <= 1'b0;
      draw_start_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      vblank_q_r   <= bus.vblank;
      fb_we_r      <= 1'b0;
      fb_swap_r    <= 1'b0;
      frame_done_r <= 1'b0;
      draw_start_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.frame_req) begin
            state_r <= S_CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        // Terminal compare against the last pixel, so non-power-of-2 sizes stop correctly.
        S_CLEAR: begin
          fb_we_r   <= 1'b1;
          fb_addr_r <= cnt_r;
          fb_data_r <= CLEAR_VALUE;
          if (cnt_r == LAST_ADDR) begin
            state_r       <= S_DRAW;
            start_armed_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ADDR_WIDTH'(1);
          end
        end
        S_DRAW: begin
          draw_start_r  <= start_armed_r;
          start_armed_r <= 1'b0;
          fb_we_r       <= bus.plot_we & plot_in_range_s;
          fb_addr_r     <= bus.plot_addr;
          fb_data_r     <= bus.plot_data;
          if (bus.draw_done) begin
            state_r <= S_WAIT_VBLANK;
          end
        end
        // vblank_q tracks vblank every cycle, so a level already high on entry is no edge.
        S_WAIT_VBLANK: begin
          if (bus.vblank && !vblank_q_r) begin
            state_r      <= S_SWAP;
            fb_swap_r    <= 1'b1;
            frame_done_r <= 1'b1;
          end
        end
        S_SWAP: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fb_write_enable = fb_we_r;
  assign bus.fb_write_addr   = fb_addr_r;
  assign bus.fb_write_data   = fb_data_r;
  assign bus.fb_swap         = fb_swap_r;
  assign bus.frame_done      = frame_done_r;
  assign bus.draw_start      = draw_start_r;
  assign bus.busy            = busy_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench: an 8-pixel (4x2) and a 9-pixel (3x3) sequencer share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_frame_sequencer;

  localparam int N_A = 8;
  localparam int N_B = 9;

  localparam int PH_IDLE  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_DRAW  = 2;
  localparam int PH_WAIT  = 3;
  localparam int PH_SWAP  = 4;

  typedef struct {
    int phase;
    int pos;
    bit start_due;
    bit vb_prev;
    int hold;
    bit we;
    int addr;
    bit data;
    bit swap;
    bit start;
    bit busy;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_req, vblank, draw_done, plot_we, plot_data;
  logic [3:0] plot_addr;
  int         n_checks = 0;
  int         n_fail   = 0;
  mdl_t       mdl_a, mdl_b;

  frame_sequencer_if #(.ADDR_WIDTH(3)) if_a ();
  frame_sequencer_if #(.ADDR_WIDTH(4)) if_b ();

  assign if_a.frame_req = frame_req;
  assign if_a.vblank    = vblank;
  assign if_a.draw_done = draw_done;
  assign if_a.plot_we   = plot_we;
  assign if_a.plot_addr = plot_addr[2:0];
  assign if_a.plot_data = plot_data;
  assign if_b.frame_req = frame_req;
  assign if_b.vblank    = vblank;
  assign if_b.draw_done = draw_done;
  assign if_b.plot_we   = plot_we;
  assign if_b.plot_addr = plot_addr;
  assign if_b.plot_data = plot_data;

  frame_sequencer #(.HOR_ACTIVE_PIXELS(4), .VER_ACTIVE_PIXELS(2), .CLEAR_VALUE(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  frame_sequencer #(.HOR_ACTIVE_PIXELS(3), .VER_ACTIVE_PIXELS(3), .CLEAR_VALUE(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '{default: 0};
    m.hold = 2;
    return m;
  endfunction

  // One clock of the frame rules: clear N pixels in order, pass legal plotter writes,
  // swap one cycle after a vblank rising edge seen while waiting.
  function automatic mdl_t mdl_step(mdl_t m, int n, int amask, bit fr, bit vb, bit dd,
                                    bit pw, int pa, bit pd);
    mdl_t r;
    r = m;
    if (m.hold > 0) begin
      r = mdl_reset();
      r.hold = m.hold - 1;
      return r;
    end
    r.we = 1'b0; r.swap = 1'b0; r.start = 1'b0;
    r.vb_prev = vb;
    case (m.phase)
      PH_IDLE: if (fr) begin r.phase = PH_CLEAR; r.pos = 0; end
      PH_CLEAR: begin
        r.we = 1'b1; r.addr = m.pos; r.data = 1'b0;
        if (m.pos == n - 1) begin r.phase = PH_DRAW; r.start_due = 1'b1; end
        else r.pos = m.pos + 1;
      end
      PH_DRAW: begin
        r.start = m.start_due; r.start_due = 1'b0;
        r.addr = pa & amask; r.data = pd;
        r.we = pw && ((pa & amask) < n);
        if (dd) r.phase = PH_WAIT;
      end
      PH_WAIT: if (vb && !m.vb_prev) begin r.phase = PH_SWAP; r.swap = 1'b1; end
      default: r.phase = PH_IDLE;
    endcase
    r.busy = (r.phase != PH_IDLE);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_a <= mdl_reset();
      mdl_b <= mdl_reset();
    end else begin
      mdl_a <= mdl_step(mdl_a, N_A, 7, frame_req, vblank, draw_done, plot_we,
                        int'(plot_addr), plot_data);
      mdl_b <= mdl_step(mdl_b, N_B, 15, frame_req, vblank, draw_done, plot_we,
                        int'(plot_addr), plot_data);
    end
  end

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic cmp_outputs();
    check_value("a_we",    int'(if_a.fb_write_enable), int'(mdl_a.we));
    check_value("a_swap",  int'(if_a.fb_swap),         int'(mdl_a.swap));
    check_value("a_done",  int'(if_a.frame_done),      int'(mdl_a.swap));
    check_value("a_start", int'(if_a.draw_start),      int'(mdl_a.start));
    check_value("a_busy",  int'(if_a.busy),            int'(mdl_a.busy));
    if (mdl_a.we) begin
      check_value("a_addr", int'(if_a.fb_write_addr), mdl_a.addr);
      check_value("a_data", int'(if_a.fb_write_data), int'(mdl_a.data));
    end
    check_value("b_we",    int'(if_b.fb_write_enable), int'(mdl_b.we));
    check_value("b_swap",  int'(if_b.fb_swap),         int'(mdl_b.swap));
    check_value("b_done",  int'(if_b.frame_done),      int'(mdl_b.swap));
    check_value("b_start", int'(if_b.draw_start),      int'(mdl_b.start));
    check_value("b_busy",  int'(if_b.busy),            int'(mdl_b.busy));
    if (mdl_b.we) begin
      check_value("b_addr", int'(if_b.fb_write_addr), mdl_b.addr);
      check_value("b_data", int'(if_b.fb_write_data), int'(mdl_b.data));
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_outputs();
  endtask

  task automatic quiet();
    frame_req = 1'b0; draw_done = 1'b0; plot_we = 1'b0; plot_addr = 4'd0; plot_data = 1'b0;
  endtask

  task automatic wait_swap(input string tag);
    int i;
    i = 0;
    while (!mdl_a.swap && i < 40) begin
      step();
      i++;
    end
    check_value(tag, int'(mdl_a.swap), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    vblank = 1'b0;
    quiet();
    // Reset held with random inputs: every output must stay low.
    for (int i = 0; i < 5; i++) begin
      frame_req = 1'($urandom); vblank = 1'($urandom); draw_done = 1'($urandom);
      plot_we = 1'($urandom); plot_addr = 4'($urandom); plot_data = 1'($urandom);
      step();
      check_value("rst_busy_a", int'(if_a.busy), 0);
      check_value("rst_we_a", int'(if_a.fb_write_enable), 0);
    end
    quiet(); vblank = 1'b0;
    rst_n = 1'b1;
    repeat (5) step();

    // Frame 1: clear, with a frame_req mid-clear that must be ignored.
    frame_req = 1'b1; step(); frame_req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      frame_req = (i == 4);
      step();
    end
    frame_req = 1'b0;
    plot_we = 1'b1; plot_addr = 4'd3; plot_data = 1'b1; step();
    plot_addr = 4'd9; step();
    plot_we = 1'b0; frame_req = 1'b1; step();
    frame_req = 1'b0; vblank = 1'b1; step(); step();
    plot_we = 1'b1; plot_addr = 4'd5; plot_data = 1'b1; draw_done = 1'b1; step();
    quiet();
    repeat (5) step();
    check_value("no_swap_on_high_vblank", int'(if_a.fb_swap | if_b.fb_swap), 0);
    vblank = 1'b0; step(); step();
    vblank = 1'b1;
    wait_swap("swap_after_edge");
    // frame_req during the swap cycle is ignored; the following cycle it is accepted.
    frame_req = 1'b1; step(); step(); frame_req = 1'b0;

    // Frame 2: abandon mid-clear with an asynchronous reset.
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    cmp_outputs();
    check_value("midclear_rst_we", int'(if_a.fb_write_enable), 0);
    check_value("midclear_rst_busy", int'(if_a.busy), 0);
    repeat (3) step();
    rst_n = 1'b1;
    vblank = 1'b0;
    repeat (20) step();
    check_value("no_swap_after_rst", int'(if_a.fb_swap), 0);

    // Frame 3: restart clears from address 0, empty draw.
    frame_req = 1'b1; step(); frame_req = 1'b0;
    repeat (14) step();
    draw_done = 1'b1; step(); draw_done = 1'b0;
    step(); vblank = 1'b1;
    wait_swap("swap_empty_frame");
    vblank = 1'b0;

    // Random traffic against the model, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      frame_req = ($urandom_range(0, 99) < 6);
      draw_done = ($urandom_range(0, 99) < 5);
      plot_we   = 1'($urandom);
      plot_addr = 4'($urandom_range(0, 15));
      plot_data = 1'($urandom);
      if ($urandom_range(0, 99) < 10) vblank = ~vblank;
      if ($urandom_range(0, 999) < 2) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    quiet();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
